// File: rtl/bt_cmd_uart_tx_if.sv
// rtl/bt_cmd_uart_tx_if.sv - key pulse input and UART/status outputs of bt_cmd_uart_tx
//
// Signals:
//   keyPulse  [NUM_KEYS]            one-cycle button pulses into the command queue
//   txd                             8N1 UART serial out, idle high
//   busy                            queue non-empty or frame in progress
//   overflow                        sticky drop flag
//   fifoCount [log2(FIFO_DEPTH)+1]  queue occupancy
// Modports: master drives keyPulse (button side), slave is the transmitter.
interface bt_cmd_uart_tx_if #(
  parameter int NUM_KEYS   = 4,
  parameter int FIFO_DEPTH = 4
);
  logic [NUM_KEYS-1:0]         keyPulse;
  logic                        txd;
  logic                        busy;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;

  modport master (output keyPulse, input txd, busy, overflow, fifoCount);
  modport slave  (input keyPulse, output txd, busy, overflow, fifoCount);
endinterface

// File: rtl/bt_cmd_uart_tx.sv
// rtl/bt_cmd_uart_tx.sv - button pulse to command byte queue and 8N1 UART transmitter
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bt_cmd_uart_tx_if.slave: keyPulse in; txd, busy, overflow, fifoCount out
module bt_cmd_uart_tx #(
  parameter int         CLK_FREQ   = 100000000,
  parameter int         BAUD       = 9600,
  parameter int         NUM_KEYS   = 4,
  parameter logic [7:0] CMD_BASE   = 8'h30,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bt_cmd_uart_tx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CNTW         = AW + 1;

  localparam logic [CW-1:0]       BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0]     FULL_CNT  = CNTW'(FIFO_DEPTH);
  localparam logic [NUM_KEYS-1:0] ONE_KEY   = NUM_KEYS'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            ovf_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic       any_key, multi_key, full, push, pop, drop;
  logic [7:0] push_byte;

  // Lowest set key wins; every other key in the same cycle is a drop.
  always_comb begin
    push_byte = CMD_BASE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (bus.keyPulse[i]) push_byte = CMD_BASE + 8'(i);
    end
  end

  assign any_key   = |bus.keyPulse;
  assign multi_key = |(bus.keyPulse & (bus.keyPulse - ONE_KEY));
  // Full is judged on the pre-edge count, so a same-cycle pop does not make room.
  assign full      = (count_q == FULL_CNT);
  assign push      = any_key & ~full;
  assign drop      = multi_key | (any_key & full);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          // Pending byte goes straight into a start bit: no idle gap between frames.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  assign bus.txd       = txd_q;
  assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
  assign bus.overflow  = ovf_q;
  assign bus.fifoCount = count_q;
endmodule

// File: doc/bt_cmd_uart_tx.md
Name: bt_cmd_uart_tx

Overview:
- Downstream consumer of the per-button debounce/one-pulse stage in the bluetooth test design.
- Each button's one-cycle pulse selects a command byte, queues it in a small FIFO, and serialises it as 8N1 UART on the TX line to the bluetooth module.
- Keeps button bursts from being lost while a frame is in flight, and flags drops.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2).
- NUM_KEYS, 4, number of one-pulse button inputs.
- CMD_BASE, 8'h30, command byte for key i is CMD_BASE + i (8-bit, wraps mod 256).
- FIFO_DEPTH, 4, command queue entries (power of two, >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- keyPulse  input  NUM_KEYS  one-cycle pulses from the debounce/one-pulse stages, synchronous to clk.
- txd  output  1  UART serial out, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky; set when any pulse is dropped.
- fifoCount  output  log2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async assert, sync release): txd=1, busy=0, overflow=0, fifoCount=0, FSM=IDLE, FIFO pointers cleared.
- Reset mid-frame aborts the frame immediately: txd goes high asynchronously and queued bytes are discarded.
- Enqueue: at a clk edge where any keyPulse bit is 1:
  - Lowest set index i wins; byte CMD_BASE+i is written.
  - Other simultaneously set bits are dropped and set overflow.
- Full FIFO: push is rejected when fifoCount==FIFO_DEPTH at that edge, even if a pop occurs in the same cycle. A rejected push sets overflow.
- Simultaneous push and pop when not full: both happen, and fifoCount is unchanged.
- Pointers wrap modulo FIFO_DEPTH. overflow clears only on reset.
- FSM states: IDLE, START, DATA, STOP. Registered txd and a baud counter 0..CLKS_PER_BIT-1.
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. After bit 7 (index 7 period ends), go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Latency:
  - Pulse sampled at edge E0 writes the FIFO at E0.
  - If IDLE and the FIFO was empty, the pop occurs at E1 and txd is low from E1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy is combinational: (state != IDLE) or (fifoCount != 0).
- Pulses arriving during any state are accepted subject to the full rule. A FIFO write never disturbs the frame in progress.

Test Plan:
- Overrides for all cases: CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16), defaults otherwise.
- Pulse keyPulse=4'b0010 once from IDLE -> txd low one cycle after the pulse edge; bits 1,0,0,0,1,1,0,0 (0x31 LSB first) each 16 cycles; stop high 16 cycles; busy falls after 160 cycles; overflow=0.
- keyPulse=4'b1010 in one cycle -> only 0x31 transmitted; overflow=1 and stays 1.
- Five pulses on key 0 on consecutive cycles while the first frame starts -> 0x30 sent five times back-to-back with no idle gap between stop and start; overflow=0 (the first pop frees a slot); fifoCount peaks at 4.
- Six pulses on key 3 on consecutive cycles (queue full during the first frame) -> five 0x33 frames; sixth pulse dropped; overflow=1.
- Assert rst_n=0 during DATA bit 3 of 0x32 with 2 bytes queued -> txd=1 immediately; fifoCount=0; busy=0; no further frames after release.
- Pulse on the same cycle as the STOP-end pop with fifoCount=4 -> push rejected, overflow=1, fifoCount becomes 3.
